// File: rtl/gan_pkg.sv
// Shared definitions for the GAN control path: Q8.8 constants, mode codes,
// LFSR taps, the sequencer state type and the LFSR step function.
package gan_pkg;

  localparam int          DATA_WIDTH = 16;
  localparam logic [15:0] Q_ZERO     = 16'h0000;
  localparam logic [15:0] Q_ONE      = 16'h0100;

  localparam logic [1:0]  MODE_GEN   = 2'b00;
  localparam logic [1:0]  MODE_DISC  = 2'b01;
  localparam logic [1:0]  MODE_FULL  = 2'b10;

  localparam logic [15:0] LFSR_TAPS  = 16'hB400;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GEN,
    ST_START,
    ST_WAIT,
    ST_EMIT,
    ST_FINISH
  } seq_state_t;

  // Galois right-shift step
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/gan_latent_lfsr.sv
// 16-bit Galois LFSR with seed load; presents the sign-extended Q8.8 sample
// taken from the value the register will hold after the next step.
module gan_latent_lfsr #(
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  parameter int          DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [15:0]           seed,
  input  logic                  step,
  output logic [DATA_WIDTH-1:0] sample
);
  import gan_pkg::*;

  logic [15:0] lfsr_q;
  logic [15:0] stepped;

  assign stepped = lfsr_step(lfsr_q);
  assign sample  = DATA_WIDTH'(signed'(stepped[8:0]));

  // a zero seed would lock the LFSR, so it falls back to the reset seed
  always_ff @(posedge clk) begin
    if (!rst_n)
      lfsr_q <= LFSR_SEED;
    else if (load)
      lfsr_q <= (seed == 16'h0000) ? LFSR_SEED : seed;
    else if (step)
      lfsr_q <= stepped;
  end

endmodule

// File: rtl/gan_batch_sequencer.sv
// Batch sequencer: builds LFSR latent vectors, starts the GAN, captures the
// score of each sample and streams it out over valid/ready.
//
// state  | meaning
// IDLE   | waiting for cfg_start; seed loads honoured here
// GEN    | one latent element per cycle from the LFSR
// START  | pulse gan_start as soon as the GAN is not busy
// WAIT   | waiting for gan_done under the watchdog
// EMIT   | result held on res_* until accepted
// FINISH | one-cycle batch_done
module gan_batch_sequencer #(
  parameter int          LATENT_DIM  = 2,
  parameter int          DATA_WIDTH  = 16,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter int          TIMEOUT_CYC = 1023
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             cfg_start,
  input  logic [1:0]                       cfg_mode,
  input  logic [7:0]                       cfg_batch_len,
  input  logic                             cfg_seed_load,
  input  logic [15:0]                      cfg_seed,
  input  logic                             abort,
  output logic [1:0]                       gan_mode,
  output logic                             gan_start,
  output logic [LATENT_DIM*DATA_WIDTH-1:0] latent_out,
  input  logic                             gan_busy,
  input  logic                             gan_done,
  input  logic [DATA_WIDTH-1:0]            gan_score,
  output logic                             res_valid,
  input  logic                             res_ready,
  output logic [7:0]                       res_index,
  output logic [DATA_WIDTH-1:0]            res_score,
  output logic                             busy,
  output logic                             batch_done,
  output logic                             err_timeout
);
  import gan_pkg::*;

  localparam int               WD_W     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0]  WD_LOAD  = WD_W'(TIMEOUT_CYC - 1);
  localparam logic [7:0]       GEN_LAST = 8'(LATENT_DIM - 1);

  seq_state_t state, state_d;

  logic [1:0]                       mode_q;
  logic [7:0]                       len_q;
  logic [7:0]                       cnt_q;
  logic [7:0]                       gen_idx;
  logic [WD_W-1:0]                  wd_q;
  logic [LATENT_DIM*DATA_WIDTH-1:0] latent_q;
  logic [DATA_WIDTH-1:0]            lfsr_sample;
  logic                             start_ok;
  logic                             last_sample;

  assign start_ok    = cfg_start && (cfg_mode == MODE_GEN || cfg_mode == MODE_DISC ||
                                     cfg_mode == MODE_FULL);
  assign last_sample = (cnt_q == 8'(len_q - 8'd1));
  assign gan_mode    = mode_q;
  assign latent_out  = latent_q;

  gan_latent_lfsr #(
    .LFSR_SEED  (LFSR_SEED),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   ((state == ST_IDLE) && cfg_seed_load),
    .seed   (cfg_seed),
    .step   ((state == ST_GEN) && !abort),
    .sample (lfsr_sample)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d    = state;
    gan_start  = 1'b0;
    res_valid  = 1'b0;
    batch_done = 1'b0;
    busy       = (state != ST_IDLE);
    case (state)
      ST_IDLE:   if (start_ok) state_d = (cfg_batch_len == 8'd0) ? ST_FINISH : ST_GEN;
      ST_GEN:    if (gen_idx == GEN_LAST) state_d = ST_START;
      ST_START: begin
        if (!gan_busy) begin
          gan_start = !abort;
          state_d   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (gan_done)          state_d = ST_EMIT;
        else if (wd_q == '0)   state_d = ST_IDLE;
      end
      ST_EMIT: begin
        res_valid = 1'b1;
        if (res_ready) state_d = last_sample ? ST_FINISH : ST_GEN;
      end
      ST_FINISH: begin
        batch_done = 1'b1;
        state_d    = ST_IDLE;
      end
      default:   state_d = ST_IDLE;
    endcase
    if (abort && state != ST_IDLE) state_d = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q      <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      gen_idx     <= '0;
      wd_q        <= '0;
      latent_q    <= '0;
      res_index   <= '0;
      res_score   <= '0;
      err_timeout <= 1'b0;
    end else begin
      gen_idx <= '0;
      case (state)
        ST_IDLE: begin
          if (start_ok) begin
            mode_q      <= cfg_mode;
            len_q       <= cfg_batch_len;
            cnt_q       <= '0;
            err_timeout <= 1'b0;
          end
        end
        ST_GEN: begin
          if (!abort) begin
            for (int i = 0; i < LATENT_DIM; i++)
              if (gen_idx == 8'(i)) latent_q[i*DATA_WIDTH +: DATA_WIDTH] <= lfsr_sample;
            gen_idx <= gen_idx + 8'd1;
          end
        end
        ST_START: wd_q <= WD_LOAD;
        ST_WAIT: begin
          if (!abort) begin
            if (gan_done) begin
              res_index <= cnt_q;
              res_score <= (mode_q == MODE_GEN) ? DATA_WIDTH'(Q_ZERO) : gan_score;
            end else if (wd_q == '0) begin
              err_timeout <= 1'b1;
            end else begin
              wd_q <= wd_q - 1'b1;
            end
          end
        end
        ST_EMIT: if (!abort && res_ready && !last_sample) cnt_q <= cnt_q + 8'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gan_batch_sequencer.sv
// Self-checking bench for gan_batch_sequencer: GAN stub, randomized consumer,
// and a transaction-level model of latents, results and batch completion.
module tb_gan_batch_sequencer;

  localparam int LD = 2;
  localparam int DW = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            cfg_start, cfg_seed_load, abort;
  logic [1:0]      cfg_mode;
  logic [7:0]      cfg_batch_len;
  logic [15:0]     cfg_seed;
  logic [1:0]      gan_mode;
  logic            gan_start;
  logic [LD*DW-1:0] latent_out;
  logic            gan_busy, gan_done;
  logic [DW-1:0]   gan_score;
  logic            res_valid, res_ready;
  logic [7:0]      res_index;
  logic [DW-1:0]   res_score;
  logic            busy, batch_done, err_timeout;

  always #5 clk = ~clk;

  gan_batch_sequencer #(
    .LATENT_DIM  (LD),
    .DATA_WIDTH  (DW),
    .LFSR_SEED   (16'hACE1),
    .TIMEOUT_CYC (1023)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cfg_start     (cfg_start),
    .cfg_mode      (cfg_mode),
    .cfg_batch_len (cfg_batch_len),
    .cfg_seed_load (cfg_seed_load),
    .cfg_seed      (cfg_seed),
    .abort         (abort),
    .gan_mode      (gan_mode),
    .gan_start     (gan_start),
    .latent_out    (latent_out),
    .gan_busy      (gan_busy),
    .gan_done      (gan_done),
    .gan_score     (gan_score),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_index     (res_index),
    .res_score     (res_score),
    .busy          (busy),
    .batch_done    (batch_done),
    .err_timeout   (err_timeout)
  );

  int n_err = 0;
  int n_checks = 0;
  int cyc = 0;

  // model state
  logic [15:0] m_lfsr = 16'hACE1;
  logic [31:0] mdl_lat;
  logic [15:0] exp_q[$];
  logic [1:0]  batch_mode = 2'b00;
  bit          batch_active = 0, outstanding = 0;
  int          exp_len = 0, accepts = 0, starts_in_batch = 0;
  int          start_count = 0, bd_count = 0;
  int          last_start_cyc = 0, last_bd_cyc = 0, last_accept_cyc = 0, issue_cyc = 0;
  logic [31:0] last_latent = '0;
  logic [15:0] last_res_score = '0;
  logic [7:0]  last_res_index = '0;

  // stub / consumer knobs
  bit          stub_rand = 0, stub_hang = 0, stub_clear = 0, force_busy = 0, stub_fixed = 0;
  int          stub_delay = 2;
  logic [15:0] stub_score = 16'h0000;
  int          ready_hold = 0, ready_pct = 100;
  bit          ready_block = 0;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [15:0] sx9(input logic [15:0] s);
    return {{7{s[8]}}, s[8:0]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // compare process: model updated from observed handshakes, DUT checked against it
  initial forever begin
    @(negedge clk);
    cyc++;
    if (rst_n) begin
      if (gan_start) begin
        mdl_lat = '0;
        for (int i = 0; i < LD; i++) begin
          m_lfsr = lfsr_next(m_lfsr);
          mdl_lat[i*16 +: 16] = sx9(m_lfsr);
        end
        chk("latent_out", 64'(latent_out), 64'(mdl_lat));
        chk("gan_mode", 64'(gan_mode), 64'(batch_mode));
        chk("start_before_accept", 64'(starts_in_batch), 64'(accepts));
        starts_in_batch++;
        start_count++;
        last_start_cyc = cyc;
        last_latent = latent_out;
        outstanding = 1;
      end
      if (gan_done && outstanding) begin
        exp_q.push_back(batch_mode == 2'b00 ? 16'h0000 : gan_score);
        outstanding = 0;
      end
      if (res_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL res_valid: got valid with index %0d, expected no pending result", res_index);
        end else begin
          chk("res_index", 64'(res_index), 64'(accepts));
          chk("res_score", 64'(res_score), 64'(exp_q[0]));
        end
        last_res_score = res_score;
        last_res_index = res_index;
        if (res_ready) begin
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          accepts++;
          last_accept_cyc = cyc;
        end
      end
      if (batch_done) begin
        chk("batch_done_expected", 64'(batch_active), 64'd1);
        chk("batch_done_count", 64'(accepts), 64'(exp_len));
        batch_active = 0;
        bd_count++;
        last_bd_cyc = cyc;
      end
      if (abort && busy) begin
        batch_active = 0;
        outstanding = 0;
        exp_q.delete();
      end
    end
  end

  // GAN stub
  initial begin
    bit take, kill, pending;
    int wait_left;
    gan_busy = 0; gan_done = 0; gan_score = '0; pending = 0; wait_left = 0;
    forever begin
      @(negedge clk);
      take = gan_start;
      kill = abort && busy;
      @(posedge clk); #1;
      gan_done = 0;
      if (!rst_n || kill || stub_clear) pending = 0;
      else if (take) begin
        pending = 1;
        wait_left = stub_rand ? int'($urandom_range(0, 6)) : stub_delay;
      end else if (pending && !stub_hang) begin
        if (wait_left == 0) begin
          gan_done = 1;
          gan_score = stub_fixed ? stub_score : 16'($urandom);
          pending = 0;
        end else wait_left--;
      end
      gan_busy = force_busy || pending;
    end
  end

  // result consumer
  initial begin
    int vcnt;
    res_ready = 0; vcnt = 0;
    forever begin
      @(posedge clk); #1;
      if (!res_valid || ready_block) begin
        res_ready = 0;
        vcnt = 0;
      end else begin
        res_ready = (vcnt >= ready_hold) && (int'($urandom_range(0, 99)) < ready_pct);
        vcnt++;
      end
    end
  end

  task automatic issue(input logic [1:0] mode, input logic [7:0] len,
                       input bit do_seed, input logic [15:0] seed);
    @(posedge clk); #1;
    cfg_start = 1; cfg_mode = mode; cfg_batch_len = len;
    cfg_seed_load = do_seed; cfg_seed = seed;
    if (do_seed) m_lfsr = (seed == 16'h0000) ? 16'hACE1 : seed;
    if (mode != 2'b11) begin
      batch_active = 1; batch_mode = mode; exp_len = int'(len);
      accepts = 0; starts_in_batch = 0; outstanding = 0; exp_q.delete();
    end
    issue_cyc = cyc + 1;
    @(posedge clk); #1;
    cfg_start = 0; cfg_seed_load = 0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while (busy && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    n_checks++;
    if (busy) begin
      n_err++;
      $display("FAIL %s: still busy after %0d cycles, expected idle", tag, budget);
    end
  endtask

  task automatic wait_start(input int budget, input string tag);
    int c0 = start_count;
    int n = 0;
    while (start_count == c0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    n_checks++;
    if (start_count == c0) begin
      n_err++;
      $display("FAIL %s: no gan_start within %0d cycles, expected one", tag, budget);
    end
  endtask

  task automatic pulse_abort();
    abort = 1;
    @(posedge clk); #1;
    abort = 0;
  endtask

  initial begin
    #600000;
    $display("FAIL global_timeout: simulation still running at cycle %0d, expected finish", cyc);
    $fatal(1, "bench time limit");
  end

  initial begin
    int bd0, sc0;
    rst_n = 0; cfg_start = 0; cfg_mode = 0; cfg_batch_len = 0;
    cfg_seed_load = 0; cfg_seed = 0; abort = 0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_gan_start", 64'(gan_start), 64'd0);
    chk("rst_batch_done", 64'(batch_done), 64'd0);
    chk("rst_err_timeout", 64'(err_timeout), 64'd0);
    chk("rst_latent", 64'(latent_out), 64'd0);
    chk("rst_gan_mode", 64'(gan_mode), 64'd0);
    m_lfsr = 16'hACE1;
    rst_n = 1;

    // single sample, mode 10, fixed score
    stub_fixed = 1; stub_score = 16'h0123; stub_delay = 2;
    issue(2'b10, 8'd1, 0, 16'h0000);
    wait_idle(200, "t1_idle");
    chk("t1_start_latency", 64'(last_start_cyc - issue_cyc), 64'd3);
    chk("t1_latent_literal", 64'(last_latent), 64'hFF38_0070);
    chk("t1_res_score_literal", 64'(last_res_score), 64'h0123);
    chk("t1_res_index_literal", 64'(last_res_index), 64'd0);
    chk("t1_done_after_accept", 64'(last_bd_cyc - last_accept_cyc), 64'd1);
    chk("t1_bd_count", 64'(bd_count), 64'd1);
    stub_fixed = 0;

    // mode 00, three samples, consumer stalls 10 cycles on each
    ready_hold = 10; sc0 = start_count; bd0 = bd_count;
    issue(2'b00, 8'd3, 0, 16'h0000);
    wait_idle(400, "t2_idle");
    chk("t2_start_pulses", 64'(start_count - sc0), 64'd3);
    chk("t2_accepts", 64'(accepts), 64'd3);
    chk("t2_bd", 64'(bd_count - bd0), 64'd1);
    ready_hold = 0;

    // empty batch and illegal mode
    sc0 = start_count; bd0 = bd_count;
    issue(2'b01, 8'd0, 0, 16'h0000);
    wait_idle(20, "t3_idle");
    chk("t3_len0_done_latency", 64'(last_bd_cyc - issue_cyc), 64'd1);
    chk("t3_len0_no_start", 64'(start_count - sc0), 64'd0);
    issue(2'b11, 8'd4, 0, 16'h0000);
    chk("t3_mode11_busy", 64'(busy), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("t3_mode11_no_start", 64'(start_count - sc0), 64'd0);

    // watchdog timeout, then clear on next start
    stub_hang = 1; bd0 = bd_count;
    issue(2'b01, 8'd1, 0, 16'h0000);
    wait_start(20, "t4_start");
    begin
      int n = 0;
      while (!err_timeout && n < 1200) begin
        @(posedge clk); #1;
        n++;
      end
    end
    chk("t4_err_set", 64'(err_timeout), 64'd1);
    chk("t4_timeout_latency", 64'(cyc + 1 - last_start_cyc), 64'd1024);
    chk("t4_idle", 64'(busy), 64'd0);
    chk("t4_no_batch_done", 64'(bd_count - bd0), 64'd0);
    batch_active = 0; outstanding = 0;
    stub_hang = 0; stub_clear = 1;
    @(posedge clk); #1;
    stub_clear = 0;
    @(posedge clk); #1;
    issue(2'b00, 8'd1, 0, 16'h0000);
    chk("t4_err_cleared", 64'(err_timeout), 64'd0);
    wait_idle(200, "t4_idle2");

    // abort in WAIT, abort in EMIT, then a batch continuing the LFSR
    stub_delay = 40; bd0 = bd_count;
    issue(2'b01, 8'd3, 0, 16'h0000);
    wait_start(20, "t5_start");
    repeat (3) @(posedge clk);
    #1;
    pulse_abort();
    chk("t5_wait_abort_busy", 64'(busy), 64'd0);
    chk("t5_wait_abort_valid", 64'(res_valid), 64'd0);
    stub_delay = 2; ready_block = 1;
    issue(2'b10, 8'd2, 0, 16'h0000);
    begin
      int n = 0;
      while (!res_valid && n < 100) begin
        @(posedge clk); #1;
        n++;
      end
    end
    chk("t5_emit_reached", 64'(res_valid), 64'd1);
    pulse_abort();
    chk("t5_emit_abort_busy", 64'(busy), 64'd0);
    chk("t5_emit_abort_valid", 64'(res_valid), 64'd0);
    ready_block = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("t5_no_batch_done", 64'(bd_count - bd0), 64'd0);
    issue(2'b10, 8'd2, 0, 16'h0000);
    wait_idle(200, "t5_idle");
    chk("t5_follow_bd", 64'(bd_count - bd0), 64'd1);

    // gan_busy held high on entry to START
    force_busy = 1; sc0 = start_count;
    issue(2'b01, 8'd1, 0, 16'h0000);
    repeat (7) @(posedge clk);
    #1;
    chk("t6_held_no_start", 64'(start_count - sc0), 64'd0);
    chk("t6_held_busy", 64'(busy), 64'd1);
    force_busy = 0;
    wait_idle(200, "t6_idle");
    chk("t6_single_start", 64'(start_count - sc0), 64'd1);

    // randomized batches
    stub_rand = 1;
    for (int b = 0; b < 24; b++) begin
      logic [1:0]  md;
      logic [7:0]  ln;
      logic [15:0] sd;
      bit          sl;
      md = (($urandom_range(0, 7)) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      ln = 8'($urandom_range(0, 4));
      sl = ($urandom_range(0, 3) == 0);
      sd = ($urandom_range(0, 4) == 0) ? 16'h0000 : 16'($urandom);
      ready_pct = int'($urandom_range(30, 100));
      bd0 = bd_count;
      issue(md, ln, sl, sd);
      if (md == 2'b11) begin
        chk("rnd_mode11_busy", 64'(busy), 64'd0);
      end else begin
        wait_idle(2000, "rnd_idle");
        chk("rnd_bd", 64'(bd_count - bd0), 64'd1);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
